rgb2hsv_stream: RTL and testbench

Parametrised, fully pipelined RGB-to-HSV converter for the camera colour-tracking path. It accepts one pixel per clock with a valid strobe and produces H, S and V at a fixed latency. It adds an in-pipeline hue/saturation/value window detector and a per-frame matched-pixel counter for marker tracking. It carries a user sideband (pixel coordinates) alongside each pixel, and its divisions are built in (pipelined restoring dividers), with no external divider core.

---
 rtl/rgb2hsv_stream_if.sv | 45 ++++
 rtl/rgb2hsv_stream.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_rgb2hsv_stream.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rgb2hsv_stream_if.sv
// Pixel stream bundle for rgb2hsv_stream: RGB input side, match window, HSV output side
// and the per-frame matched-pixel total.
interface rgb2hsv_stream_if #(
    parameter int unsigned W      = 8,
    parameter int unsigned USER_W = 20,
    parameter int unsigned CNT_W  = 20
) ();
    logic              in_valid;
    logic [W-1:0]      in_r;
    logic [W-1:0]      in_g;
    logic [W-1:0]      in_b;
    logic [USER_W-1:0] in_user;
    logic              in_sof;
    logic              in_eof;

    logic [W-1:0]      h_lo;
    logic [W-1:0]      h_hi;
    logic [W-1:0]      s_min;
    logic [W-1:0]      v_min;

    logic              out_valid;
    logic [W-1:0]      out_h;
    logic [W-1:0]      out_s;
    logic [W-1:0]      out_v;
    logic              out_match;
    logic [USER_W-1:0] out_user;
    logic              out_sof;
    logic              out_eof;
    logic [CNT_W-1:0]  match_total;
    logic              match_total_valid;

    modport master (
        output in_valid, in_r, in_g, in_b, in_user, in_sof, in_eof,
        output h_lo, h_hi, s_min, v_min,
        input  out_valid, out_h, out_s, out_v, out_match, out_user, out_sof, out_eof,
        input  match_total, match_total_valid
    );

    modport slave (
        input  in_valid, in_r, in_g, in_b, in_user, in_sof, in_eof,
        input  h_lo, h_hi, s_min, v_min,
        output out_valid, out_h, out_s, out_v, out_match, out_user, out_sof, out_eof,
        output match_total, match_total_valid
    );
endinterface

// File: rtl/rgb2hsv_stream.sv
// Fully pipelined RGB-to-HSV converter (latency W+4) with HSV window match and a
// per-frame matched-pixel counter. Divisions use two W-stage restoring dividers.
module rgb2hsv_stream #(
    parameter int unsigned W      = 8,
    parameter int unsigned USER_W = 20,
    parameter int unsigned CNT_W  = 20
) (
    input logic            clock,
    input logic            reset,
    rgb2hsv_stream_if.slave bus
);
    localparam int unsigned NW     = 2 * W + 3;
    localparam int unsigned DW     = W + 3;
    localparam int unsigned HMAX_I = (2 ** W) - 1;
    localparam logic [W-1:0] HMAX  = W'(HMAX_I);
    localparam logic [W-1:0] OFF_G = W'(HMAX_I / 3);
    localparam logic [W-1:0] OFF_B = W'((2 * HMAX_I) / 3);

    typedef enum logic [1:0] {SecR, SecG, SecB} sector_e;

    typedef struct packed {
        logic              valid;
        logic [USER_W-1:0] user;
        logic              sof;
        logic              eof;
    } meta_t;

    typedef struct packed {
        logic         neg;
        logic         dzero;
        logic         mzero;
        logic [W-1:0] offset;
        logic [W-1:0] vmax;
    } hue_t;

    // Stage 1: input register
    meta_t        m1_q;
    logic [W-1:0] r1_q, g1_q, b1_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m1_q <= '0;
            r1_q <= '0;
            g1_q <= '0;
            b1_q <= '0;
        end else begin
            m1_q.valid <= bus.in_valid;
            m1_q.user  <= bus.in_user;
            m1_q.sof   <= bus.in_sof;
            m1_q.eof   <= bus.in_eof;
            r1_q       <= bus.in_r;
            g1_q       <= bus.in_g;
            b1_q       <= bus.in_b;
        end
    end

    // Stage 2: max/min and sector, R beats G beats B on ties
    sector_e      sec_d, sec2_q;
    logic [W-1:0] max_d, min_d;
    logic [W-1:0] max2_q, min2_q, r2_q, g2_q, b2_q;
    meta_t        m2_q;

    always_comb begin
        sec_d = SecB;
        max_d = b1_q;
        if (r1_q >= g1_q && r1_q >= b1_q) begin
            sec_d = SecR;
            max_d = r1_q;
        end else if (g1_q >= b1_q) begin
            sec_d = SecG;
            max_d = g1_q;
        end
        min_d = r1_q;
        if (g1_q < min_d) min_d = g1_q;
        if (b1_q < min_d) min_d = b1_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sec2_q <= SecR;
            max2_q <= '0;
            min2_q <= '0;
            r2_q   <= '0;
            g2_q   <= '0;
            b2_q   <= '0;
            m2_q   <= '0;
        end else begin
            sec2_q <= sec_d;
            max2_q <= max_d;
            min2_q <= min_d;
            r2_q   <= r1_q;
            g2_q   <= g1_q;
            b2_q   <= b1_q;
            m2_q   <= m1_q;
        end
    end

    // Stage 3 feeds divider slot 0; slots 1..W each resolve one quotient bit, MSB first.
    logic [NW-1:0] srem_d [W];
    logic [NW-1:0] srem_q [W];
    logic [NW-1:0] hrem_d [W];
    logic [NW-1:0] hrem_q [W];
    logic [W-1:0]  sden_d [W];
    logic [W-1:0]  sden_q [W];
    logic [DW-1:0] hden_d [W];
    logic [DW-1:0] hden_q [W];
    logic [W-1:0]  sq_d   [W+1];
    logic [W-1:0]  sq_q   [W+1];
    logic [W-1:0]  hq_d   [W+1];
    logic [W-1:0]  hq_q   [W+1];
    meta_t         m_d    [W+1];
    meta_t         m_q    [W+1];
    hue_t          hue_d  [W+1];
    hue_t          hue_q  [W+1];

    logic [W-1:0]  delta, op_a, op_b, diff, offset;
    logic          neg;
    logic [NW-1:0] s_sh [W];
    logic [NW-1:0] h_sh [W];
    logic [W-1:0]  s_bit, h_bit;

    always_comb begin
        delta  = max2_q - min2_q;
        op_a   = r2_q;
        op_b   = g2_q;
        offset = OFF_B;
        case (sec2_q)
            SecR: begin
                op_a   = g2_q;
                op_b   = b2_q;
                offset = '0;
            end
            SecG: begin
                op_a   = b2_q;
                op_b   = r2_q;
                offset = OFF_G;
            end
            default: ;
        endcase
        neg  = op_a < op_b;
        diff = neg ? (op_b - op_a) : (op_a - op_b);

        srem_d[0] = NW'(delta) * NW'(HMAX);
        sden_d[0] = (max2_q == '0) ? W'(1) : max2_q;
        hrem_d[0] = NW'(diff) * NW'(HMAX);
        hden_d[0] = (delta == '0) ? DW'(6) : DW'(delta) * DW'(6);
        sq_d[0]   = '0;
        hq_d[0]   = '0;
        m_d[0]    = m2_q;
        hue_d[0]        = '0;
        hue_d[0].neg    = neg;
        hue_d[0].dzero  = (delta == '0);
        hue_d[0].mzero  = (max2_q == '0);
        hue_d[0].offset = offset;
        hue_d[0].vmax   = max2_q;

        for (int j = 0; j < W; j++) begin
            s_sh[j]    = NW'(sden_q[j]) << (W - 1 - j);
            h_sh[j]    = NW'(hden_q[j]) << (W - 1 - j);
            s_bit[j]   = srem_q[j] >= s_sh[j];
            h_bit[j]   = hrem_q[j] >= h_sh[j];
            sq_d[j+1]  = {sq_q[j][W-2:0], s_bit[j]};
            hq_d[j+1]  = {hq_q[j][W-2:0], h_bit[j]};
            m_d[j+1]   = m_q[j];
            hue_d[j+1] = hue_q[j];
        end
        for (int j = 0; j < W - 1; j++) begin
            srem_d[j+1] = s_bit[j] ? (srem_q[j] - s_sh[j]) : srem_q[j];
            hrem_d[j+1] = h_bit[j] ? (hrem_q[j] - h_sh[j]) : hrem_q[j];
            sden_d[j+1] = sden_q[j];
            hden_d[j+1] = hden_q[j];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < W; j++) begin
                srem_q[j] <= '0;
                hrem_q[j] <= '0;
                sden_q[j] <= '0;
                hden_q[j] <= '0;
            end
            for (int j = 0; j <= W; j++) begin
                sq_q[j]  <= '0;
                hq_q[j]  <= '0;
                m_q[j]   <= '0;
                hue_q[j] <= '0;
            end
        end else begin
            for (int j = 0; j < W; j++) begin
                srem_q[j] <= srem_d[j];
                hrem_q[j] <= hrem_d[j];
                sden_q[j] <= sden_d[j];
                hden_q[j] <= hden_d[j];
            end
            for (int j = 0; j <= W; j++) begin
                sq_q[j]  <= sq_d[j];
                hq_q[j]  <= hq_d[j];
                m_q[j]   <= m_d[j];
                hue_q[j] <= hue_d[j];
            end
        end
    end

    // Final stage: hue reconstruction and window test (window inputs used live here)
    hue_t         hf;
    logic [W-1:0] qh, h_d, s_d, v_d;
    logic         hue_in, match_d;

    always_comb begin
        hf  = hue_q[W];
        qh  = hq_q[W];
        if (hf.dzero) begin
            h_d = '0;
        end else if (!hf.neg) begin
            h_d = hf.offset + qh;
        end else if (hf.offset >= qh) begin
            h_d = hf.offset - qh;
        end else begin
            // True result fits W bits, so modular W-bit arithmetic is exact.
            h_d = hf.offset + HMAX - qh;
        end
        s_d = hf.mzero ? '0 : sq_q[W];
        v_d = hf.vmax;
        if (bus.h_lo <= bus.h_hi) begin
            hue_in = (h_d >= bus.h_lo) && (h_d <= bus.h_hi);
        end else begin
            hue_in = (h_d >= bus.h_lo) || (h_d <= bus.h_hi);
        end
        match_d = hue_in && (s_d >= bus.s_min) && (v_d >= bus.v_min);
    end

    logic              out_valid_q, out_match_q, out_sof_q, out_eof_q;
    logic [W-1:0]      out_h_q, out_s_q, out_v_q;
    logic [USER_W-1:0] out_user_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_match_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            out_h_q     <= '0;
            out_s_q     <= '0;
            out_v_q     <= '0;
            out_user_q  <= '0;
        end else begin
            out_valid_q <= m_q[W].valid;
            out_match_q <= match_d;
            out_sof_q   <= m_q[W].sof;
            out_eof_q   <= m_q[W].eof;
            out_h_q     <= h_d;
            out_s_q     <= s_d;
            out_v_q     <= v_d;
            out_user_q  <= m_q[W].user;
        end
    end

    // Frame counter works on the registered output pixels
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_sum, total_q, total_d;
    logic             total_valid_q, total_valid_d;

    always_comb begin
        cnt_sum       = cnt_q;
        cnt_d         = cnt_q;
        total_d       = total_q;
        total_valid_d = 1'b0;
        if (out_valid_q) begin
            if (out_sof_q) begin
                cnt_sum = CNT_W'(out_match_q);
            end else if (out_match_q && (cnt_q != '1)) begin
                cnt_sum = cnt_q + CNT_W'(1);
            end
            cnt_d = cnt_sum;
            if (out_eof_q) begin
                total_d       = cnt_sum;
                total_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q         <= '0;
            total_q       <= '0;
            total_valid_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            total_q       <= total_d;
            total_valid_q <= total_valid_d;
        end
    end

    assign bus.out_valid         = out_valid_q;
    assign bus.out_h             = out_h_q;
    assign bus.out_s             = out_s_q;
    assign bus.out_v             = out_v_q;
    assign bus.out_match         = out_match_q;
    assign bus.out_user          = out_user_q;
    assign bus.out_sof           = out_sof_q;
    assign bus.out_eof           = out_eof_q;
    assign bus.match_total       = total_q;
    assign bus.match_total_valid = total_valid_q;
endmodule

// File: tb/tb_rgb2hsv_stream.sv
// Self-checking bench for rgb2hsv_stream: W=8 and W=10 instances, directed cases, a frame
// count test, random stimulus against an arithmetic HSV model, and a mid-frame reset.
module tb_rgb2hsv_stream;
    localparam int L8  = 12;
    localparam int L10 = 14;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    rgb2hsv_stream_if #(.W(8),  .USER_W(20), .CNT_W(20)) i8 ();
    rgb2hsv_stream_if #(.W(10), .USER_W(20), .CNT_W(20)) i10 ();

    rgb2hsv_stream #(.W(8),  .USER_W(20), .CNT_W(20)) u8  (.clock(clock), .reset(reset), .bus(i8));
    rgb2hsv_stream #(.W(10), .USER_W(20), .CNT_W(20)) u10 (.clock(clock), .reset(reset), .bus(i10));

    typedef struct {
        int     h;
        int     s;
        int     v;
        int     user;
        bit     sof;
        bit     eof;
        longint due;
    } exp_t;

    exp_t   q8[$];
    exp_t   q10[$];
    longint cyc = 0;
    int     n_cmp = 0;
    int     n_bad = 0;

    int lo8, hi8, smin8, vmin8, lo10, hi10, smin10, vmin10;
    int lo8_s, hi8_s, smin8_s, vmin8_s, lo10_s, hi10_s, smin10_s, vmin10_s;
    int cnt8 = 0, pend_val8 = 0, pulses8 = 0, last_tot8 = -1;
    bit pend8 = 0;

    always @(posedge clock) begin
        cyc      <= cyc + 1;
        // Window values in force at this edge are what the DUT's output stage used.
        lo8_s    <= lo8;
        hi8_s    <= hi8;
        smin8_s  <= smin8;
        vmin8_s  <= vmin8;
        lo10_s   <= lo10;
        hi10_s   <= hi10;
        smin10_s <= smin10;
        vmin10_s <= vmin10;
    end

    task automatic check_eq(input string tag, input longint got, input longint want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic void hsv_model(input int r, input int g, input int b, input int w,
                                      output int h, output int s, output int v);
        int hmax, mx, mn, d, a, c, off, q;
        hmax = (1 << w) - 1;
        mx = r; if (g > mx) mx = g; if (b > mx) mx = b;
        mn = r; if (g < mn) mn = g; if (b < mn) mn = b;
        d = mx - mn;
        v = mx;
        s = (mx == 0) ? 0 : (d * hmax) / mx;
        if (r == mx) begin
            a = g; c = b; off = 0;
        end else if (g == mx) begin
            a = b; c = r; off = hmax / 3;
        end else begin
            a = r; c = g; off = (2 * hmax) / 3;
        end
        if (d == 0) h = 0;
        else begin
            q = ((a > c) ? a - c : c - a) * hmax / (6 * d);
            if (a >= c) h = off + q;
            else if (off >= q) h = off - q;
            else h = off + hmax - q;
        end
    endfunction

    function automatic bit in_win(input int h, input int s, input int v, input int lo,
                                  input int hi, input int smin, input int vmin);
        bit hue_ok;
        hue_ok = (lo <= hi) ? (h >= lo && h <= hi) : (h >= lo || h <= hi);
        return hue_ok && s >= smin && v >= vmin;
    endfunction

    function automatic int rc(input int w);
        int hmax;
        hmax = (1 << w) - 1;
        case ($urandom % 8)
            0: return 0;
            1: return hmax;
            2: return hmax / 2;
            default: return int'($urandom % (hmax + 1));
        endcase
    endfunction

    task automatic put8(input bit vld, input int r, input int g, input int b, input int user,
                        input bit sof, input bit eof,
                        input int fh = -1, input int fs = -1, input int fv = -1);
        exp_t e;
        int h, s, v;
        i8.in_valid = vld; i8.in_r = 8'(r); i8.in_g = 8'(g); i8.in_b = 8'(b);
        i8.in_user = 20'(user); i8.in_sof = sof; i8.in_eof = eof;
        if (vld) begin
            hsv_model(r, g, b, 8, h, s, v);
            if (fh >= 0) begin h = fh; s = fs; v = fv; end
            e.h = h; e.s = s; e.v = v; e.user = user; e.sof = sof; e.eof = eof;
            e.due = cyc + L8;
            q8.push_back(e);
        end
    endtask

    task automatic put10(input bit vld, input int r, input int g, input int b, input int user,
                         input bit sof, input bit eof);
        exp_t e;
        int h, s, v;
        i10.in_valid = vld; i10.in_r = 10'(r); i10.in_g = 10'(g); i10.in_b = 10'(b);
        i10.in_user = 20'(user); i10.in_sof = sof; i10.in_eof = eof;
        if (vld) begin
            hsv_model(r, g, b, 10, h, s, v);
            e.h = h; e.s = s; e.v = v; e.user = user; e.sof = sof; e.eof = eof;
            e.due = cyc + L10;
            q10.push_back(e);
        end
    endtask

    task automatic setwin8(input int lo, input int hi, input int smin, input int vmin);
        lo8 = lo; hi8 = hi; smin8 = smin; vmin8 = vmin;
        i8.h_lo = 8'(lo); i8.h_hi = 8'(hi); i8.s_min = 8'(smin); i8.v_min = 8'(vmin);
    endtask

    task automatic setwin10(input int lo, input int hi, input int smin, input int vmin);
        lo10 = lo; hi10 = hi; smin10 = smin; vmin10 = vmin;
        i10.h_lo = 10'(lo); i10.h_hi = 10'(hi); i10.s_min = 10'(smin); i10.v_min = 10'(vmin);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle8();
        put8(0, rc(8), rc(8), rc(8), int'($urandom % 1048576), $urandom % 2, $urandom % 2);
    endtask

    task automatic idle10();
        put10(0, rc(10), rc(10), rc(10), int'($urandom % 1048576), $urandom % 2, $urandom % 2);
    endtask

    task automatic drain(input int n);
        repeat (n) begin
            tick();
            idle8();
            idle10();
        end
    endtask

    exp_t e8, e10;

    always @(negedge clock) begin
        if (!reset) begin
            if (i8.match_total_valid) begin
                pulses8++;
                last_tot8 = int'(i8.match_total);
            end
            if (pend8) begin
                check_eq("total_valid", i8.match_total_valid, 1);
                check_eq("match_total", i8.match_total, pend_val8);
                pend8 = 0;
            end else if (i8.match_total_valid) begin
                check_eq("stray_total_valid", i8.match_total_valid, 0);
            end
            if (q8.size() > 0 && q8[0].due < cyc) begin
                check_eq("missing8", cyc, q8[0].due);
                void'(q8.pop_front());
            end
            if (i8.out_valid) begin
                if (q8.size() == 0) check_eq("spurious8", i8.out_valid, 0);
                else begin
                    e8 = q8.pop_front();
                    check_eq("lat8", cyc, e8.due);
                    check_eq("h8", i8.out_h, e8.h);
                    check_eq("s8", i8.out_s, e8.s);
                    check_eq("v8", i8.out_v, e8.v);
                    check_eq("match8", i8.out_match,
                             in_win(e8.h, e8.s, e8.v, lo8_s, hi8_s, smin8_s, vmin8_s));
                    check_eq("user8", i8.out_user, e8.user);
                    check_eq("sof8", i8.out_sof, e8.sof);
                    check_eq("eof8", i8.out_eof, e8.eof);
                    if (e8.sof) cnt8 = in_win(e8.h, e8.s, e8.v, lo8_s, hi8_s, smin8_s, vmin8_s);
                    else if (in_win(e8.h, e8.s, e8.v, lo8_s, hi8_s, smin8_s, vmin8_s)
                             && cnt8 < 1048575) cnt8++;
                    if (e8.eof) begin
                        pend8 = 1;
                        pend_val8 = cnt8;
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            if (q10.size() > 0 && q10[0].due < cyc) begin
                check_eq("missing10", cyc, q10[0].due);
                void'(q10.pop_front());
            end
            if (i10.out_valid) begin
                if (q10.size() == 0) check_eq("spurious10", i10.out_valid, 0);
                else begin
                    e10 = q10.pop_front();
                    check_eq("lat10", cyc, e10.due);
                    check_eq("h10", i10.out_h, e10.h);
                    check_eq("s10", i10.out_s, e10.s);
                    check_eq("v10", i10.out_v, e10.v);
                    check_eq("match10", i10.out_match,
                             in_win(e10.h, e10.s, e10.v, lo10_s, hi10_s, smin10_s, vmin10_s));
                    check_eq("user10", i10.out_user, e10.user);
                    check_eq("flags10", {i10.out_sof, i10.out_eof}, {e10.sof, e10.eof});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    int fr[10][3] = '{'{255, 0, 51}, '{0, 255, 0}, '{255, 0, 0}, '{0, 0, 255},
                      '{255, 20, 0}, '{128, 128, 128}, '{10, 0, 0}, '{200, 0, 10},
                      '{255, 255, 0}, '{0, 0, 0}};
    int p0;

    initial begin
        setwin8(0, 255, 0, 0);
        setwin10(0, 1023, 0, 0);
        put8(0, 0, 0, 0, 0, 0, 0);
        put10(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("rst_out_valid8", i8.out_valid, 0);
        check_eq("rst_out_h8", i8.out_h, 0);
        check_eq("rst_match_total", i8.match_total, 0);
        check_eq("rst_total_valid", i8.match_total_valid, 0);
        check_eq("rst_out_valid10", i10.out_valid, 0);
        tick();
        reset = 1'b0;

        // Directed colours with hand-computed results
        setwin8(240, 10, 128, 64);
        tick(); put8(1, 255, 0, 0, 1, 0, 0, 0, 255, 255);
        tick(); put8(1, 0, 255, 0, 2, 0, 0, 85, 255, 255);
        tick(); put8(1, 0, 0, 255, 3, 0, 0, 170, 255, 255);
        tick(); put8(1, 255, 0, 51, 4, 0, 0, 247, 255, 255);
        tick(); put8(1, 0, 0, 0, 5, 0, 0, 0, 0, 0);
        tick(); put8(1, 128, 128, 128, 6, 0, 0, 0, 0, 128);
        drain(L8 + 2);
        setwin8(240, 10, 128, 101);
        tick(); put8(1, 100, 0, 0, 7, 0, 0, 0, 255, 100);
        drain(L8 + 2);

        // Ten-pixel frame with four in-window pixels and input gaps
        setwin8(240, 10, 128, 64);
        p0 = pulses8;
        for (int i = 0; i < 10; i++) begin
            tick();
            put8(1, fr[i][0], fr[i][1], fr[i][2], 100 + i, i == 0, i == 9);
            repeat ($urandom % 3) begin
                tick();
                idle8();
            end
        end
        drain(L8 + 4);
        check_eq("frame_total", last_tot8, 4);
        check_eq("frame_pulses", pulses8 - p0, 1);

        // Random pixels, gaps, flags and window changes on both widths
        for (int i = 0; i < 13500; i++) begin
            tick();
            if (i % 500 == 0) begin
                setwin8($urandom % 256, $urandom % 256, $urandom % 200, $urandom % 128);
                setwin10($urandom % 1024, $urandom % 1024, $urandom % 800, $urandom % 512);
            end
            put8($urandom % 4 != 0, rc(8), rc(8), rc(8), int'($urandom % 1048576),
                 $urandom % 12 == 0, $urandom % 12 == 0);
            put10($urandom % 4 != 0, rc(10), rc(10), rc(10), int'($urandom % 1048576),
                  $urandom % 12 == 0, $urandom % 12 == 0);
        end
        drain(L10 + 4);

        // Reset with five pixels of an unfinished frame in flight
        setwin8(240, 10, 128, 64);
        p0 = pulses8;
        for (int i = 0; i < 5; i++) begin
            tick();
            put8(1, 255, 0, 51, 200 + i, i == 0, i == 4);
        end
        tick();
        idle8();
        idle10();
        reset = 1'b1;
        q8.delete();
        q10.delete();
        cnt8 = 0;
        pend8 = 0;
        @(negedge clock);
        check_eq("rst_flight_valid8", i8.out_valid, 0);
        check_eq("rst_flight_total_valid", i8.match_total_valid, 0);
        check_eq("rst_flight_valid10", i10.out_valid, 0);
        tick();
        tick();
        reset = 1'b0;
        drain(L8 + 4);
        check_eq("rst_no_pulse", pulses8 - p0, 0);
        tick(); put8(1, 255, 0, 51, 300, 1, 0);
        tick(); put8(1, 0, 255, 0, 301, 0, 0);
        tick(); put8(1, 255, 0, 0, 302, 0, 1);
        drain(L8 + 4);
        check_eq("post_rst_total", last_tot8, 2);
        check_eq("post_rst_pulses", pulses8 - p0, 1);

        check_eq("drain8", q8.size(), 0);
        check_eq("drain10", q10.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
